// File: rtl/ibwt_decoder.sv
// ibwt_decoder: inverse Burrows-Wheeler transform by walking the LF mapping
module ibwt_decoder #(
    parameter int STRING_LEN = 8,
    parameter int IDX_W = $clog2(STRING_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] primary_idx,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [2:0] {IDLE, LOAD, PREFIX, WALK, DONE} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(STRING_LEN - 1);

    state_t state_q, state_d;
    logic [IDX_W-1:0] p_q, p_d, wcnt_q, wcnt_d, j_q, j_d, out_idx_q, out_idx_d, j_nx;
    logic [IDX_W:0] acc_q, acc_d;
    logic [7:0] c_q, c_d, out_data_q, out_data_d;
    logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic ld_we, pf_we;
    logic [7:0] lbuf_q [STRING_LEN];
    logic [IDX_W-1:0] rank_q [STRING_LEN];
    logic [IDX_W:0] occ_q [256];
    logic [IDX_W:0] ctab_q [256];

    // next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        p_d = p_q;
        wcnt_d = wcnt_q;
        j_d = j_q;
        acc_d = acc_q;
        c_d = c_q;
        in_ready_d = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d = out_data_q;
        out_idx_d = out_idx_q;
        busy_d = busy_q;
        done_d = 1'b0;
        err_d = err_q;
        ld_we = 1'b0;
        pf_we = 1'b0;
        j_nx = IDX_W'(ctab_q[lbuf_q[j_q]] + {1'b0, rank_q[j_q]});
        case (state_q)
            IDLE: if (start) begin
                p_d = primary_idx;
                wcnt_d = '0;
                err_d = int'(primary_idx) >= STRING_LEN;
                busy_d = !err_d;
                done_d = err_d;
                in_ready_d = !err_d;
                state_d = err_d ? DONE : LOAD;
            end
            LOAD: if (in_valid && in_ready_q) begin
                ld_we = 1'b1;
                wcnt_d = wcnt_q + IDX_W'(1);
                if (wcnt_q == LAST) begin
                    in_ready_d = 1'b0;
                    c_d = '0;
                    acc_d = '0;
                    state_d = PREFIX;
                end
            end
            PREFIX: begin
                pf_we = 1'b1;
                acc_d = acc_q + occ_q[c_q];
                c_d = c_q + 8'd1;
                j_d = p_q;
                state_d = (c_q == 8'hff) ? WALK : PREFIX;
            end
            WALK: if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d = lbuf_q[j_q];
                out_idx_d = LAST;
            end else if (out_ready) begin
                if (out_idx_q == '0) begin
                    out_valid_d = 1'b0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    state_d = DONE;
                end else begin
                    j_d = j_nx;
                    out_data_d = lbuf_q[j_nx];
                    out_idx_d = out_idx_q - IDX_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q <= '0;
            wcnt_q <= '0;
            j_q <= '0;
            acc_q <= '0;
            c_q <= '0;
            in_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_idx_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q <= p_d;
            wcnt_q <= wcnt_d;
            j_q <= j_d;
            acc_q <= acc_d;
            c_q <= c_d;
            in_ready_q <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_idx_q <= out_idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end

    // symbol histogram: counts during load, self-clears during the prefix pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int i = 0; i < 256; i++) occ_q[i] <= '0;
        else if (ld_we) occ_q[in_data] <= occ_q[in_data] + (IDX_W+1)'(1);
        else if (pf_we) occ_q[c_q] <= '0;
    end

    // L column, per-byte ranks and exclusive prefix sums
    always_ff @(posedge clk) begin
        if (ld_we) begin
            lbuf_q[wcnt_q] <= in_data;
            rank_q[wcnt_q] <= occ_q[in_data][IDX_W-1:0];
        end
        if (pf_we) ctab_q[c_q] <= acc_q;
    end

    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_idx = out_idx_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
endmodule

// File: tb/tb_ibwt_decoder.sv
// tb_ibwt_decoder: scoreboard bench using a forward-BWT reference model
module tb_ibwt_decoder;
    localparam int N = 8;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 1;
    logic [2:0] primary_idx = 0;
    logic [7:0] in_data = 0;
    logic in_ready, out_valid, busy, done, err;
    logic [7:0] out_data;
    logic [2:0] out_idx;
    logic b_start = 0, b_in_valid = 0;
    logic [2:0] b_pidx = 0;
    logic [7:0] b_in_data = 0;
    logic b_in_ready, b_out_valid, b_busy, b_done, b_err;
    logic [7:0] b_out_data;
    logic [2:0] b_out_idx;
    int tests = 0, fails = 0, cyc = 0, s_cyc = 0, last_hs = 0, hs_cnt = 0, bp = 0, ph = 0;
    bit lat_chk = 0, first_pend = 0, prev_stall = 0;
    logic [10:0] prev;
    logic [15:0] exp_q[$];

    ibwt_decoder u_dut (.clk(clk), .rst(rst), .start(start), .primary_idx(primary_idx),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .busy(busy),
        .done(done), .err(err));

    ibwt_decoder #(.STRING_LEN(6)) u_bad (.clk(clk), .rst(rst), .start(b_start),
        .primary_idx(b_pidx), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(1'b1),
        .out_data(b_out_data), .out_idx(b_out_idx), .busy(b_busy), .done(b_done),
        .err(b_err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // forward BWT: sort all rotations, L is the last column, p the original row
    task automatic bwt(input logic [7:0] s[N], output logic [7:0] l[N], output int p);
        logic [63:0] rot[N];
        int ord[N], t;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) rot[i][63-8*k -: 8] = s[(i+k)%N];
            ord[i] = i;
        end
        for (int a = 0; a < N; a++)
            for (int b = 0; b < N-1-a; b++)
                if (rot[ord[b]] > rot[ord[b+1]]) begin t = ord[b]; ord[b] = ord[b+1]; ord[b+1] = t; end
        p = -1;
        for (int r = 0; r < N; r++) begin
            l[r] = s[(ord[r]+N-1)%N];
            if (p < 0 && rot[ord[r]] == rot[0]) p = r;
        end
    endtask

    // out_ready driver: always ready, fixed 1,0,0,1 pattern, or random
    initial forever begin
        @(posedge clk); #1;
        out_ready = (bp == 0) ? 1'b1 : (bp == 1) ? (ph == 0 || ph == 3) : 1'($urandom % 2);
        ph = (ph + 1) % 4;
    end

    // monitor: scoreboard pops, hold-while-stalled, latency and done timing
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            prev_stall = 0;
            first_pend = 0;
        end else begin
            if (start && !busy) begin s_cyc = cyc; first_pend = 1; end
            if (out_valid) begin
                if (first_pend) begin
                    first_pend = 0;
                    if (lat_chk) cmp("first_lat", cyc - s_cyc, 266);
                end
                if (prev_stall) cmp("hold", {21'd0, out_idx, out_data}, {21'd0, prev});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_out: got idx %0d data %0d expected none", out_idx, out_data);
                end else begin
                    e = exp_q.pop_front();
                    cmp("out_idx", out_idx, e[15:8]);
                    cmp("out_data", out_data, e[7:0]);
                end
                hs_cnt++;
                last_hs = cyc;
            end
            if (done) cmp("done_lat", cyc - last_hs, 1);
            prev_stall = out_valid && !out_ready;
            prev = {out_idx, out_data};
        end
    end

    task automatic run_block(input logic [63:0] str, input int pov, input bit gaps,
                             input int bpm, input bit poke, input bit abort);
        logic [7:0] s[N], l[N];
        int p, guard;
        bit acc, poked;
        for (int i = 0; i < N; i++) s[i] = str[63-8*i -: 8];
        bwt(s, l, p);
        if (pov >= 0) p = pov;
        for (int k = N-1; k >= 0; k--) exp_q.push_back({8'(k), s[k]});
        bp = bpm;
        lat_chk = !gaps;
        hs_cnt = 0;
        @(posedge clk); #1;
        start = 1; primary_idx = 3'(p);
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < N; i++) begin
            acc = 0; guard = 0;
            while (!acc) begin
                in_valid = gaps ? 1'($urandom % 2) : 1'b1;
                in_data = l[i];
                if (poke && i == 3) begin start = 1; primary_idx = primary_idx + 3'd1; end
                @(negedge clk);
                acc = in_valid && in_ready;
                if (++guard > 200) begin
                    $display("FAIL load_timeout: got no in_ready expected acceptance");
                    $fatal(1);
                end
                @(posedge clk); #1;
                start = 0;
            end
        end
        in_valid = 0;
        cmp("in_ready_drop", in_ready, 0);
        guard = 0; poked = 0;
        do begin
            @(negedge clk);
            guard++;
            if (abort && hs_cnt >= 3) begin
                rst = 1; #1;
                cmp("rst_in_ready", in_ready, 0);
                cmp("rst_out_valid", out_valid, 0);
                cmp("rst_out_data", out_data, 0);
                cmp("rst_out_idx", out_idx, 0);
                cmp("rst_busy", busy, 0);
                exp_q.delete();
                @(negedge clk); rst = 0;
                return;
            end
            if (poke && out_valid && !poked) begin start = 1; poked = 1; end
            else start = 0;
        end while (!done && guard < 3000);
        start = 0;
        cmp("done_seen", done, 1);
        cmp("drain", exp_q.size(), 0);
    endtask

    initial begin
        int sv, sr, dn, guard;
        logic [63:0] str;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_in_ready", in_ready, 0);
        cmp("reset_out_valid", out_valid, 0);
        cmp("reset_out_data", out_data, 0);
        cmp("reset_out_idx", out_idx, 0);
        cmp("reset_busy", busy, 0);
        cmp("reset_done", done, 0);
        cmp("reset_err", err, 0);
        rst = 0;
        run_block("ABCDEFGH", 0, 0, 0, 0, 0);
        run_block("BABABABA", 4, 0, 0, 0, 0);
        run_block("AAAAAAAA", 3, 0, 0, 0, 0);
        run_block("ABCDEFGH", 0, 1, 1, 1, 0);
        run_block("ABCDEFGH", 0, 0, 0, 0, 1);
        run_block("ABCDEFGH", 0, 0, 0, 0, 0);
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) str[63-8*i -: 8] = 8'h41 + 8'($urandom % 3);
            run_block(str, -1, 1'($urandom % 2), 2, 1'($urandom % 2), 0);
        end
        bp = 0;
        // out-of-range primary index on a 6-byte decoder
        b_in_valid = 1; b_in_data = 8'h5a;
        @(posedge clk); #1;
        b_pidx = 3'd7; b_start = 1;
        @(posedge clk); #1;
        b_start = 0;
        sv = 0; sr = 0; dn = 0;
        repeat (10) begin
            @(negedge clk);
            sv += int'(b_out_valid); sr += int'(b_in_ready); dn += int'(b_done);
        end
        cmp("bad_err", b_err, 1);
        cmp("bad_no_valid", sv, 0);
        cmp("bad_no_ready", sr, 0);
        cmp("bad_done_pulses", dn, 1);
        cmp("bad_busy", b_busy, 0);
        @(posedge clk); #1;
        b_pidx = 3'd2; b_start = 1;
        @(posedge clk); #1;
        b_start = 0;
        cmp("bad_err_clear", b_err, 0);
        cmp("bad_busy_restart", b_busy, 1);
        guard = 0;
        do begin @(negedge clk); guard++; end while (!b_done && guard < 1000);
        cmp("bad_done_nohang", b_done, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
